// File: rtl/ci_test_supervisor.sv
// ci_test_supervisor: drives reset into a self-checking test, watches fail/finish/timeout, reports verdict
module ci_test_supervisor #(
    parameter int          RESET_CYCLES = 4,
    parameter logic [31:0] TIMEOUT      = 32'd1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        fail,
    input  logic        finish,
    output logic        test_reset,
    output logic        done,
    output logic        pass,
    output logic        timed_out,
    output logic [31:0] cycles
);

    typedef enum logic [2:0] {ST_RST, ST_RUN, ST_PASS, ST_FAIL, ST_TMO} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(RESET_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [31:0] cycles_q, cycles_d;
    logic        test_reset_q, test_reset_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timed_out_q, timed_out_d;

    // Next state: reset window, run with fail>finish>timeout priority, sticky verdicts until start
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        cycles_d     = cycles_q;
        test_reset_d = test_reset_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timed_out_d  = timed_out_q;
        case (state_q)
            ST_RST: begin
                if (hold_q == HOLD_LAST) begin
                    state_d      = ST_RUN;
                    test_reset_d = 1'b0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_RUN: begin
                cycles_d = cycles_q + 32'd1;
                if (fail) begin
                    state_d = ST_FAIL;
                    done_d  = 1'b1;
                end else if (finish) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else if (cycles_q + 32'd1 == TIMEOUT) begin
                    state_d     = ST_TMO;
                    done_d      = 1'b1;
                    timed_out_d = 1'b1;
                end
            end
            ST_PASS, ST_FAIL, ST_TMO: begin
                if (start) begin
                    state_d      = ST_RST;
                    hold_d       = 8'd0;
                    cycles_d     = 32'd0;
                    test_reset_d = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    timed_out_d  = 1'b0;
                end
            end
            default: begin
                state_d      = ST_RST;
                hold_d       = 8'd0;
                cycles_d     = 32'd0;
                test_reset_d = 1'b1;
                done_d       = 1'b0;
                pass_d       = 1'b0;
                timed_out_d  = 1'b0;
            end
        endcase
        if (reset) begin
            state_d      = ST_RST;
            hold_d       = 8'd0;
            cycles_d     = 32'd0;
            test_reset_d = 1'b1;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            timed_out_d  = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        state_q      <= state_d;
        hold_q       <= hold_d;
        cycles_q     <= cycles_d;
        test_reset_q <= test_reset_d;
        done_q       <= done_d;
        pass_q       <= pass_d;
        timed_out_q  <= timed_out_d;
    end

    assign test_reset = test_reset_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timed_out  = timed_out_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_ci_test_supervisor.sv
// tb_ci_test_supervisor: directed runs with a scoreboard checking verdicts and reset-window lengths
module tb_ci_test_supervisor;

    typedef struct packed {
        logic        pass;
        logic        tmo;
        logic [31:0] cycles;
    } result_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        fail = 1'b0;
    logic        finish = 1'b0;
    logic        test_reset, done, pass, timed_out;
    logic [31:0] cycles;

    int checks = 0;
    int errors = 0;

    result_t exp_res[$];
    int      exp_len[$];

    ci_test_supervisor #(.RESET_CYCLES(4), .TIMEOUT(32'd10)) dut (
        .clock(clock), .reset(reset), .start(start), .fail(fail), .finish(finish),
        .test_reset(test_reset), .done(done), .pass(pass), .timed_out(timed_out), .cycles(cycles)
    );

    always #5 clock = ~clock;

    // Monitor: verdict on done rising, reset-window length on test_reset falling
    logic prev_done = 1'b0;
    logic prev_tr = 1'b0;
    int   tr_len = 0;
    always @(negedge clock) begin
        result_t e, a;
        int l;
        if (done === 1'b1 && prev_done !== 1'b1) begin
            a = '{pass, timed_out, cycles};
            checks++;
            if (exp_res.size() == 0) begin
                errors++;
                $display("FAIL verdict: unexpected done, got pass=%b tmo=%b cycles=%0d", pass, timed_out, cycles);
            end else begin
                e = exp_res.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL verdict: got pass=%b tmo=%b cycles=%0d, want pass=%b tmo=%b cycles=%0d",
                             a.pass, a.tmo, a.cycles, e.pass, e.tmo, e.cycles);
                end
            end
        end
        if (prev_tr === 1'b1 && test_reset === 1'b0) begin
            checks++;
            if (exp_len.size() == 0) begin
                errors++;
                $display("FAIL rst_window: unexpected release after %0d cycles", tr_len);
            end else begin
                l = exp_len.pop_front();
                if (tr_len != l) begin
                    errors++;
                    $display("FAIL rst_window: got %0d cycles, want %0d", tr_len, l);
                end
            end
            tr_len = 0;
        end else if (reset === 1'b1) begin
            tr_len = 0;
        end else if (test_reset === 1'b1) begin
            tr_len++;
        end
        prev_done = done;
        prev_tr = test_reset;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 60 && done !== 1'b1; i++) tick(1);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done got %b, want 1 within 60 cycles", done);
        end
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_test_reset", {31'd0, test_reset}, 1);
        check("rst_done", {31'd0, done}, 0);
        check("rst_pass", {31'd0, pass}, 0);
        check("rst_tmo", {31'd0, timed_out}, 0);
        check("rst_cycles", cycles, 0);

        // finish held from release
        exp_len.push_back(4);
        exp_res.push_back('{1'b1, 1'b0, 32'd1});
        finish = 1'b1;
        reset = 1'b0;
        wait_done();
        finish = 1'b0;

        // sticky terminal state
        fail = 1'b1;
        tick(3);
        fail = 1'b0;
        check("sticky_pass", {31'd0, pass}, 1);
        check("sticky_cycles", cycles, 1);

        // start in PASS clears; fail+finish on RUN edge 3; start mid-RUN ignored
        exp_len.push_back(4);
        exp_res.push_back('{1'b0, 1'b0, 32'd3});
        pulse_start();
        check("start_done", {31'd0, done}, 0);
        check("start_pass", {31'd0, pass}, 0);
        check("start_cycles", cycles, 0);
        check("start_test_reset", {31'd0, test_reset}, 1);
        tick(5);
        pulse_start();
        fail = 1'b1;
        finish = 1'b1;
        tick(1);
        fail = 1'b0;
        finish = 1'b0;
        wait_done();
        check("fail_tmo", {31'd0, timed_out}, 0);

        // timeout
        exp_len.push_back(4);
        exp_res.push_back('{1'b0, 1'b1, 32'd10});
        pulse_start();
        wait_done();
        tick(3);
        check("tmo_frozen", cycles, 10);

        // fail during reset window ignored, finish on RUN edge 2
        exp_len.push_back(4);
        exp_res.push_back('{1'b1, 1'b0, 32'd2});
        pulse_start();
        fail = 1'b1;
        tick(2);
        fail = 1'b0;
        tick(3);
        finish = 1'b1;
        tick(1);
        finish = 1'b0;
        wait_done();

        // reset on RUN edge 5 aborts; full window re-run
        exp_len.push_back(4);
        pulse_start();
        tick(8);
        check("mid_run_cycles", cycles, 4);
        reset = 1'b1;
        tick(1);
        check("abort_cycles", cycles, 0);
        check("abort_test_reset", {31'd0, test_reset}, 1);
        check("abort_done", {31'd0, done}, 0);
        exp_len.push_back(4);
        exp_res.push_back('{1'b1, 1'b0, 32'd1});
        reset = 1'b0;
        finish = 1'b1;
        wait_done();
        finish = 1'b0;

        tick(2);
        check("scoreboard_res_empty", exp_res.size(), 0);
        check("scoreboard_len_empty", exp_len.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
